// File: rtl/state_receiver.sv
// Receiver for the board-to-board player-state SPI link.
// Synchronizes the SPI pins into the pixel domain, then frames, checks and presents each word.
module state_receiver #(
    parameter int unsigned DATA_WIDTH     = 90,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 400
) (
    input  logic                  clk_pixel_in,
    input  logic                  rst_n_in,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    output logic [DATA_WIDTH-2:0] player_data_out,
    output logic                  player_scored_out,
    output logic                  data_valid_out,
    output logic                  frame_error_out
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(DATA_WIDTH + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_DRAIN
    } state_e;

    logic [SYNC_STAGES-1:0] sel_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   sel_p_q;
    logic                   clk_p_q;
    logic                   sel_s;
    logic                   clk_s;
    logic                   dat_s;
    logic                   sel_fall;
    logic                   sel_rise;
    logic                   sample;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [DATA_WIDTH-2:0]  data_q, data_d;
    logic                   scored_q, scored_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    // Synchronizers reset low so a select already asserted at reset release
    // never looks like a fresh falling edge; the FSM parks in DRAIN instead.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sel_sync_q <= '0;
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            sel_p_q    <= 1'b0;
            clk_p_q    <= 1'b0;
        end else begin
            sel_sync_q <= {sel_sync_q[SYNC_STAGES-2:0], sel_in};
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], data_clk_in};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], data_in};
            sel_p_q    <= sel_s;
            clk_p_q    <= clk_s;
        end
    end

    assign sel_s    = sel_sync_q[SYNC_STAGES-1];
    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign dat_s    = dat_sync_q[SYNC_STAGES-1];
    assign sel_fall = sel_p_q & ~sel_s;
    assign sel_rise = ~sel_p_q & sel_s;
    assign sample   = clk_s & ~clk_p_q & ~sel_s;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_DRAIN;
            shift_q  <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            data_q   <= '0;
            scored_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            scored_q <= scored_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        data_d   = data_q;
        scored_d = scored_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_fall) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sample) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], dat_s};
                    // Saturating one past full keeps over-run frames distinguishable.
                    if (cnt_q != CNT_OVR) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    tmo_d = '0;
                end else if (sel_rise) begin
                    state_d = ST_CHECK;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_MAX) begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_CHECK: begin
                if (cnt_q == CNT_FULL) begin
                    data_d   = shift_q[DATA_WIDTH-1:1];
                    scored_d = shift_q[0];
                    valid_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (sel_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_DRAIN;
        endcase
    end

    assign player_data_out   = data_q;
    assign player_scored_out = scored_q;
    assign data_valid_out    = valid_q;
    assign frame_error_out   = err_q;

endmodule

// File: doc/state_receiver.md
# state_receiver

Receiving end of the inter-board player-state link. Deserializes the SPI frame produced by the opponent board's transmitter (`{data_t player_data, player_scored}`, MSB first) into a parallel `data_t` word plus scored flag. Emits a one-cycle valid pulse per good frame and a one-cycle error pulse per malformed frame. Sits between the board-to-board PMOD pins and the game FSM, all on the pixel clock domain.

## Interface
- `DATA_WIDTH`, default `$bits(data_t)+1` (90): frame length in bits.
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchronizer; minimum 2.
- `TIMEOUT_CYCLES`, default 400: maximum cycles between consecutive sampled clock edges while select is active.
- `clk_pixel_in`, input, 1: pixel clock; the only clock.
- `rst_n_in`, input, 1: reset; asynchronous, active-low.
- `data_in`, input, 1: serial data; asynchronous to `clk_pixel_in`.
- `data_clk_in`, input, 1: serial clock; asynchronous to `clk_pixel_in`.
- `sel_in`, input, 1: frame select, active-low; asynchronous to `clk_pixel_in`.
- `player_data_out`, output, `$bits(data_t)`: `data_t` field of the last good frame.
- `player_scored_out`, output, 1: LSB of the last good frame.
- `data_valid_out`, output, 1: one-cycle pulse when the outputs update.
- `frame_error_out`, output, 1: one-cycle pulse when a frame is discarded.

## Operation
- All three inputs pass through `SYNC_STAGES` flops. All logic uses only the synchronized versions (`sel_s`, `clk_s`, `dat_s`) plus one extra registered copy of each for edge detection.
- A bit is sampled when `clk_s` has a rising edge and `sel_s` is low. The bit shifts in at the LSB of a `DATA_WIDTH` shift register, so the first bit received ends at bit `DATA_WIDTH-1`.
- Bit counter width is `$clog2(DATA_WIDTH+1)`. The counter saturates at `DATA_WIDTH+1`, which marks over-run.
- FSM states:
  - IDLE: on `sel_s` falling edge, clear the counter and the timeout counter, then go to SHIFT. A falling edge of `clk_s` is ignored in this state.
  - SHIFT: sample bits as defined above. Each sampled edge clears the timeout counter; otherwise the timeout counter increments.
    - On `sel_s` rising edge, go to CHECK.
    - If the timeout counter reaches `TIMEOUT_CYCLES`, pulse `frame_error_out` and go to DRAIN.
  - CHECK (1 cycle): if count equals `DATA_WIDTH`, load `player_data_out` from `shift[DATA_WIDTH-1:1]`, load `player_scored_out` from `shift[0]`, and pulse `data_valid_out`. Otherwise pulse `frame_error_out` and leave the outputs unchanged. Go to IDLE.
  - DRAIN: wait for `sel_s` high, then go to IDLE. No sampling, no pulses.
- Out of reset, the FSM goes to DRAIN if `sel_s` is low and to IDLE otherwise. A frame already in progress is never accepted.
- `data_valid_out` and `frame_error_out` are never high in the same cycle.

## Timing
- Reset values: `player_data_out` = 0, `player_scored_out` = 0, `data_valid_out` = 0, `frame_error_out` = 0. FSM starts in DRAIN, shift register and counters are 0.
- Reset mid-frame clears everything immediately (asynchronously). No pulse is emitted for the aborted frame.
- Latency from `sel_in` rising at the pin to `data_valid_out` high is exactly `SYNC_STAGES`+2 cycles; the pulse lasts 1 cycle.
- `player_data_out` and `player_scored_out` change only in the cycle `data_valid_out` is high, and hold between good frames.
- Link requirements:
  - Serial clock high and low phases are each at least `SYNC_STAGES`+1 pixel cycles; the transmitter's 100-cycle bit period satisfies this.
  - Data is stable across the sampling edge.
  - `sel_in` is high for at least `SYNC_STAGES`+2 cycles between frames.
- A new `sel_s` falling edge is accepted in the cycle after CHECK (IDLE takes it on the next cycle it is seen), so back-to-back frames with the minimum gap are both received.

## Test plan
- Good frame: send 90 bits with `player_data` = 89'h1_5555_5555_5555_5555_5555 and scored = 1. Required: `data_valid_out` pulses once, 4 cycles after `sel_in` rises; the outputs match; no error pulse.
- Short frame: 89 edges then deselect. Required: `frame_error_out` pulses once; outputs keep the previous good frame; `data_valid_out` stays 0.
- Long frame: 95 edges. Required: `frame_error_out` pulses once and the outputs are unchanged. The next good 90-bit frame is accepted normally.
- Timeout: select low, 10 edges, then the clock stalls for 500 cycles. Required: `frame_error_out` pulses at cycle 400 after the last edge. A later `sel_in` rise produces no pulse; the next good frame is accepted.
- Reset mid-frame: assert `rst_n_in` low after bit 40, release while `sel_in` is still low, then finish the frame. Required: all outputs 0, no pulses, and the following frame is received correctly.
- Back-to-back: two good frames with different payloads and a 4-cycle gap. Required: two valid pulses with matching payloads, in order.
